// File: rtl/wav_buffer_filler.sv
// Ping-pong bank filler: streams WAV bytes into two banks, pads the tail with silence.
// Optional stall counter port is enabled by defining WAV_FILLER_STALL_CNT_EN.
module wav_buffer_filler #(
  parameter int BUFFER_SIZE_BYTES = 512,
  parameter int BUFFER_ADDR_BITS  = $clog2(BUFFER_SIZE_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        filler_start_i,
  input  logic [31:0]                 filler_data_len_i,
  input  logic [7:0]                  filler_stream_data_i,
  input  logic                        filler_stream_valid_i,
  output logic                        filler_stream_ready_o,
  output logic                        filler_buffer_we_o,
  output logic [BUFFER_ADDR_BITS-1:0] filler_buffer_addr_o,
  output logic [7:0]                  filler_buffer_data_o,
  output logic                        filler_buffer_bank_o,
  output logic                        filler_buffer_filled_o,
  input  logic                        filler_buffer_empty_i,
  output logic                        filler_buffer_empty_ack_o,
  output logic                        filler_busy_o,
  output logic                        filler_done_o
`ifdef WAV_FILLER_STALL_CNT_EN
  ,
  output logic [15:0]                 filler_stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FILL,
    FULL,
    DONE
  } state_t;

  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR =
    BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);

  state_t                      state;
  state_t                      state_d;
  logic [31:0]                 remaining;
  logic [BUFFER_ADDR_BITS-1:0] wr_ptr;
  logic                        last;

  logic in_fill;
  logic take;
  logic pad;
  logic wr;
  logic bank_end;
  logic ack_set;
  logic start_ok;
  logic stream_end;

  assign in_fill    = (state == FILL);
  assign filler_stream_ready_o = in_fill && (remaining != '0);
  assign take       = filler_stream_ready_o && filler_stream_valid_i;
  assign pad        = in_fill && (remaining == '0);
  assign wr         = take || pad;
  assign bank_end   = wr && (wr_ptr == LAST_ADDR);
  assign stream_end = (remaining == '0) || last;
  assign ack_set    = filler_buffer_empty_i && !filler_buffer_empty_ack_o
                   && ((state == ARM) || (state == FULL));
  assign start_ok   = filler_start_i && ((state == IDLE) || (state == DONE));

  assign filler_busy_o = (state == ARM) || in_fill || (state == FULL);
  assign filler_done_o = (state == DONE);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (filler_start_i)
              state_d = (filler_data_len_i == '0) ? DONE : ARM;
      ARM:  if (ack_set) state_d = FILL;
      FILL: if (bank_end) state_d = FULL;
      FULL: if (ack_set) state_d = stream_end ? DONE : FILL;
      DONE: if (filler_start_i && (filler_data_len_i != '0))
              state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filler_buffer_we_o        <= 1'b0;
      filler_buffer_addr_o      <= '0;
      filler_buffer_data_o      <= '0;
      filler_buffer_bank_o      <= 1'b1;
      filler_buffer_filled_o    <= 1'b0;
      filler_buffer_empty_ack_o <= 1'b0;
      remaining                 <= '0;
      wr_ptr                    <= '0;
      last                      <= 1'b0;
    end else begin
      filler_buffer_we_o        <= wr;
      filler_buffer_empty_ack_o <= ack_set;
      if (wr) begin
        filler_buffer_addr_o <= wr_ptr;
        filler_buffer_data_o <= take ? filler_stream_data_i : 8'h00;
        wr_ptr               <= wr_ptr + 1'b1;
      end
      if (take) remaining <= remaining - 32'd1;
      if (pad)  last      <= 1'b1;
      if (bank_end) filler_buffer_filled_o <= 1'b1;
      if ((state == FULL) && ack_set) begin
        filler_buffer_filled_o <= 1'b0;
        filler_buffer_bank_o   <= ~filler_buffer_bank_o;
      end
      // A restart from DONE keeps the bank the codec just released.
      if (start_ok) begin
        remaining <= filler_data_len_i;
        wr_ptr    <= '0;
        last      <= 1'b0;
        if (state == IDLE) filler_buffer_bank_o <= 1'b1;
      end
    end
  end

`ifdef WAV_FILLER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok)
      filler_stall_cnt_o <= '0;
    else if (filler_stream_ready_o && !filler_stream_valid_i
             && (filler_stall_cnt_o != 16'hFFFF))
      filler_stall_cnt_o <= filler_stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wav_buffer_filler.sv
// Randomized bench for wav_buffer_filler with an 8-byte bank.
// Expected bank writes come from a byte-list model of the spec.
module tb_wav_buffer_filler;

  localparam int BS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] len;
  logic [7:0]  sdata;
  logic        svalid;
  logic        ready;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  data;
  logic        bank;
  logic        filled;
  logic        empty;
  logic        ack;
  logic        busy;
  logic        done;
`ifdef WAV_FILLER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  wav_buffer_filler #(.BUFFER_SIZE_BYTES(BS)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .filler_start_i            (start),
    .filler_data_len_i         (len),
    .filler_stream_data_i      (sdata),
    .filler_stream_valid_i     (svalid),
    .filler_stream_ready_o     (ready),
    .filler_buffer_we_o        (we),
    .filler_buffer_addr_o      (addr),
    .filler_buffer_data_o      (data),
    .filler_buffer_bank_o      (bank),
    .filler_buffer_filled_o    (filled),
    .filler_buffer_empty_i     (empty),
    .filler_buffer_empty_ack_o (ack),
    .filler_busy_o             (busy),
    .filler_done_o             (done)
`ifdef WAV_FILLER_STALL_CNT_EN
    ,
    .filler_stall_cnt_o        (stall_cnt)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  bytes [64];
  logic [11:0] log_q [$];
  logic        mbank;
  int          acks;
  int          fcyc;
  int          inv;
  int          stall_m;

  task automatic drive_start(input logic [31:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Codec + stream source; the DUT is observed on the falling edge.
  task automatic run_xfer(input int l, input int vmode, input int hold,
                          input bit early, input bit from_idle);
    int idx;
    int cnt;
    int nb;
    bit ph;
    bit v;
    bit finished;
    logic [11:0] exp;
    idx = 0; cnt = 0; ph = 1'b1; finished = 1'b0;
    log_q.delete();
    acks = 0; fcyc = 0; inv = 0; stall_m = 0;
    drive_start(l);
    if (from_idle) empty = 1'b1;
    for (int c = 0; c < 2000 && !finished; c++) begin
      if (we) log_q.push_back({bank, addr, data});
      if (ack) acks++;
      if (filled) fcyc++;
      if (filled && ready) inv++;
      if (done) finished = 1'b1;
      if (ack) cnt = hold + 1;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) empty = 1'b0;
      end
      if (filled && cnt == 0) empty = 1'b1;
      if (early && busy && !filled && cnt == 0) empty = 1'b1;
      unique case (vmode)
        0: v = 1'b1;
        1: begin v = ph; ph = !ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      svalid = v;
      sdata  = bytes[idx < 64 ? idx : 63];
      if (ready && v) idx++;
      if (ready && !v) stall_m++;
      if (!finished) @(negedge clk);
    end
    svalid = 1'b0;
    empty  = 1'b0;
    nb = (l + BS - 1) / BS;
    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL timeout len=%0d: done never rose", l);
    end
    tests++;
    if (log_q.size() !== nb * BS) begin
      fails++;
      $display("FAIL write_count len=%0d: got %0d want %0d",
               l, log_q.size(), nb * BS);
    end
    for (int j = 0; j < nb * BS && j < log_q.size(); j++) begin
      exp = {mbank ^ ((j / BS) % 2 == 1), 3'(j % BS),
             (j < l) ? bytes[j] : 8'h00};
      tests++;
      if (log_q[j] !== exp) begin
        fails++;
        $display("FAIL write[%0d] len=%0d: got %03h want %03h",
                 j, l, log_q[j], exp);
      end
    end
    tests++;
    if (acks !== nb + int'(from_idle)) begin
      fails++;
      $display("FAIL ack_count len=%0d: got %0d want %0d",
               l, acks, nb + int'(from_idle));
    end
    tests++;
    if (inv !== 0) begin
      fails++;
      $display("FAIL filled_and_ready len=%0d: got %0d want 0", l, inv);
    end
    tests++;
    if (idx !== l) begin
      fails++;
      $display("FAIL bytes_taken len=%0d: got %0d want %0d", l, idx, l);
    end
    if (early) begin
      tests++;
      if (fcyc !== nb) begin
        fails++;
        $display("FAIL filled_cycles len=%0d: got %0d want %0d",
                 l, fcyc, nb);
      end
    end
`ifdef WAV_FILLER_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'(stall_m)) begin
      fails++;
      $display("FAIL stall_cnt len=%0d: got %0d want %0d",
               l, stall_cnt, stall_m);
    end
`endif
    mbank = mbank ^ nb[0];
  endtask

  task automatic check_idle_outputs(input string tag);
    tests++;
    if ({we, filled, bank, ack, busy, done, ready} !== 7'b0010000) begin
      fails++;
      $display("FAIL %s: we/fill/bank/ack/busy/done/rdy got %b want 0010000",
               tag, {we, filled, bank, ack, busy, done, ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0;
    sdata = '0; svalid = 1'b0; empty = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    tests++;
    if ({addr, data} !== 11'h0) begin
      fails++;
      $display("FAIL reset_addr_data: got %03h want 000", {addr, data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
    mbank = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 64; i++) bytes[i] = 8'(i);
    run_xfer(16, 0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_pad();
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom_range(1, 255));
    run_xfer(11, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
    run_xfer(8, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_in_fill();
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
    run_xfer(24, 2, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
      run_xfer($urandom_range(1, 40), 2, $urandom_range(0, 2), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    drive_start(16);
    empty = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (ack) empty = 1'b0;
      if (we && addr == 3'd3) hit = 1'b1;
      else begin
        svalid = 1'b1;
        sdata  = 8'($urandom);
        @(negedge clk);
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_mid_reach: got no addr-3 write want one");
    end
    rst_n  = 1'b0;
    svalid = 1'b0;
    empty  = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_after");
    mbank = 1'b1;
  endtask

  task automatic test_start_in_full();
    int wcnt;
    bit hit;
    wcnt = 0; hit = 1'b0;
    drive_start(8);
    empty = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (ack) empty = 1'b0;
      if (we) wcnt++;
      if (filled) hit = 1'b1;
      else begin
        svalid = 1'b1;
        sdata  = 8'($urandom);
        @(negedge clk);
      end
    end
    svalid = 1'b0;
    start  = 1'b1;
    len    = 32'd3;
    @(negedge clk);
    start = 1'b0;
    if (we) wcnt++;
    tests++;
    if ({hit, filled, busy, done} !== 4'b1110) begin
      fails++;
      $display("FAIL start_in_full: hit/filled/busy/done got %b want 1110",
               {hit, filled, busy, done});
    end
    empty = 1'b1;
    hit   = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (we) wcnt++;
      if (ack) hit = 1'b1;
    end
    empty = 1'b0;
    tests++;
    if ({hit, done, ready, bank} !== 4'b1100) begin
      fails++;
      $display("FAIL full_to_done: ack/done/ready/bank got %b want 1100",
               {hit, done, ready, bank});
    end
    tests++;
    if (wcnt !== 8) begin
      fails++;
      $display("FAIL start_in_full_writes: got %0d want 8", wcnt);
    end
    mbank = 1'b0;
  endtask

  task automatic test_zero_len();
    drive_start(0);
    repeat (2) begin
      tests++;
      if ({done, busy, ready, we} !== 4'b1000) begin
        fails++;
        $display("FAIL zero_len: done/busy/ready/we got %b want 1000",
                 {done, busy, ready, we});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_toggle();
    test_empty_in_fill();
    test_random();
    test_reset_mid();
    test_start_in_full();
    test_zero_len();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
